toggle_pair_monitor: RTL

//   Downstream consumer of the cross-coupled toggle pair (x <= !y, y <= !x).

---
 rtl/toggle_pair_monitor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/toggle_pair_monitor.sv
// toggle_pair_monitor
//   Watches the cross-coupled toggle pair (x <= !y, y <= !x) while en is
//   high. A sample is an error when x and y disagree or, if CHECK_TOGGLE is
//   set, when either bit failed to change since the previous cycle. Errors
//   are counted, and MAX_MISS consecutive errors latch a sticky fault.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   en         in   1      qualifier; the pair is monitored only while 1
//   x, y       in   1      pair bits from the toggle stage
//   clear      in   1      synchronous clear of fault, counters and state
//   armed      out  1      state == TRACK
//   in_sync    out  1      last TRACK sample was error-free
//   fault      out  1      sticky, state == FAULT
//   miss_cnt   out  CNT_W  saturating count of erroneous TRACK samples
//   cycle_cnt  out  CNT_W  saturating count of TRACK cycles
//   state      out  2      IDLE=0, ARM=1, TRACK=2, FAULT=3

module toggle_pair_monitor #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned MAX_MISS     = 2,
    parameter int unsigned CHECK_TOGGLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             y,
    input  logic             clear,
    output logic             armed,
    output logic             in_sync,
    output logic             fault,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StTrack = 2'd2,
        StFault = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W:0]   MaxMissW = (CNT_W + 1)'(MAX_MISS);

    state_e           state_q, state_d;
    logic             x_q, y_q;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] miss_run_q, miss_run_d;
    logic             in_sync_q, in_sync_d;

    logic             toggle_miss;
    logic             err;
    logic [CNT_W:0]   run_inc;

    assign toggle_miss = (x == x_q) || (y == y_q);
    assign err         = (x != y) || ((CHECK_TOGGLE != 0) && toggle_miss);
    // One bit wider so the fault threshold compare cannot wrap.
    assign run_inc     = {1'b0, miss_run_q} + (CNT_W + 1)'(1);

    always_comb begin
        state_d     = state_q;
        miss_cnt_d  = miss_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        miss_run_d  = miss_run_q;
        in_sync_d   = in_sync_q;

        if (clear) begin
            state_d     = StIdle;
            miss_cnt_d  = '0;
            cycle_cnt_d = '0;
            miss_run_d  = '0;
            in_sync_d   = 1'b0;
        end else if (state_q != StFault && !en) begin
            // Losing the qualifier discards the current sample entirely.
            state_d = StIdle;
            if (state_q == StTrack) begin
                miss_run_d = '0;
                in_sync_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: state_d = StArm;
                StArm: begin
                    if (x == y) begin
                        state_d = StTrack;
                    end
                end
                StTrack: begin
                    if (cycle_cnt_q != CntMax) begin
                        cycle_cnt_d = cycle_cnt_q + 1'b1;
                    end
                    if (err) begin
                        if (miss_cnt_q != CntMax) begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                        if (miss_run_q != CntMax) begin
                            miss_run_d = miss_run_q + 1'b1;
                        end
                        in_sync_d = 1'b0;
                        if (run_inc >= MaxMissW) begin
                            state_d = StFault;
                        end
                    end else begin
                        miss_run_d = '0;
                        in_sync_d  = 1'b1;
                    end
                end
                StFault: state_d = StFault;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            miss_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            miss_run_q  <= '0;
            in_sync_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x;
            y_q         <= y;
            miss_cnt_q  <= miss_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            miss_run_q  <= miss_run_d;
            in_sync_q   <= in_sync_d;
        end
    end

    assign armed     = (state_q == StTrack);
    assign fault     = (state_q == StFault);
    assign in_sync   = in_sync_q;
    assign miss_cnt  = miss_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
    assign state     = state_q;

`ifdef FORMAL
    always_comb begin
        assert (!fault || state_q == StFault);
        assert (!armed || !fault);
        assert (miss_cnt_q <= cycle_cnt_q);
    end
`endif

endmodule
